// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - control/status bundle between a reset sequencer and its host
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic                   soft_reset_req_i;
  logic [NUM_DOMAINS-1:0] domain_ready_i;
  logic [NUM_DOMAINS-1:0] domain_reset_o;
  logic                   all_ready_o;
  logic                   busy_o;
  logic                   timeout_err_o;
  logic [IDX_W-1:0]       cur_domain_o;

  modport master (
    output soft_reset_req_i, domain_ready_i,
    input  domain_reset_o, all_ready_o, busy_o, timeout_err_o, cur_domain_o
  );

  modport slave (
    input  soft_reset_req_i, domain_ready_i,
    output domain_reset_o, all_ready_o, busy_o, timeout_err_o, cur_domain_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered per-domain reset release with ready timeouts and soft re-sequencing
// RESET_STAGGER_ASSERT_EN: soft reset reasserts domains one per cycle in reverse order.
module reset_sequencer #(
  parameter int   NUM_DOMAINS     = 4,
  parameter int   DELAY_CYCLES    = 16,
  parameter int   DONE_TIMEOUT    = 255,
  parameter logic OUTPUT_POLARITY = 1'b1
) (
  input  logic               clk,
  input  logic               async_reset,
  reset_sequencer_if.slave   bus
);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
  localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [NUM_DOMAINS-1:0] ALL_ASSERTED = {NUM_DOMAINS{OUTPUT_POLARITY}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {ST_HOLD, ST_WAIT, ST_DONE, ST_SHUTDOWN} state_t;

  logic [1:0]             r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [TMR_W-1:0]       r_tmr;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_DOMAINS-1:0] r_rst;
  logic                   r_all_ready;
  logic                   r_busy;
  logic                   r_timeout_err;

  state_t                 w_state;
  logic [CNT_W-1:0]       w_cnt;
  logic [TMR_W-1:0]       w_tmr;
  logic [IDX_W-1:0]       w_idx;
  logic [NUM_DOMAINS-1:0] w_rst;
  logic                   w_all_ready;
  logic                   w_busy;
  logic                   w_timeout_err;
  logic                   w_advance;

  // Async assert, sync deassert: the FSM only moves once r_sync[1] is high.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) r_sync <= 2'b00;
    else              r_sync <= {r_sync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_state       <= ST_HOLD;
      r_cnt         <= '0;
      r_tmr         <= '0;
      r_idx         <= '0;
      r_rst         <= ALL_ASSERTED;
      r_all_ready   <= 1'b0;
      r_busy        <= 1'b1;
      r_timeout_err <= 1'b0;
    end else if (r_sync[1]) begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_tmr         <= w_tmr;
      r_idx         <= w_idx;
      r_rst         <= w_rst;
      r_all_ready   <= w_all_ready;
      r_busy        <= w_busy;
      r_timeout_err <= w_timeout_err;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_tmr         = r_tmr;
    w_idx         = r_idx;
    w_rst         = r_rst;
    w_all_ready   = r_all_ready;
    w_busy        = r_busy;
    w_timeout_err = r_timeout_err;
    w_advance     = 1'b0;

    case (r_state)
      ST_HOLD: begin
        if (r_cnt == CNT_W'(DELAY_CYCLES - 1)) begin
          w_cnt    = '0;
          w_tmr    = '0;
          w_idx    = '0;
          w_rst[0] = ~OUTPUT_POLARITY;
          w_state  = ST_WAIT;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        w_tmr = r_tmr + TMR_W'(1);
        if (bus.domain_ready_i[r_idx]) begin
          w_advance = 1'b1;
        end else if (r_tmr == TMR_W'(DONE_TIMEOUT - 1)) begin
          w_advance     = 1'b1;
          w_timeout_err = 1'b1;
        end
        if (w_advance) begin
          w_tmr = '0;
          if (r_idx == LAST_IDX) begin
            w_state     = ST_DONE;
            w_all_ready = 1'b1;
            w_busy      = 1'b0;
          end else begin
            w_idx        = r_idx + IDX_W'(1);
            w_rst[w_idx] = ~OUTPUT_POLARITY;
          end
        end
      end
      ST_DONE: begin
      end
`ifdef RESET_STAGGER_ASSERT_EN
      ST_SHUTDOWN: begin
        // Released domains always form a prefix, so all-asserted means domain 0 is back in reset.
        if (r_rst == ALL_ASSERTED) begin
          w_state = ST_HOLD;
          w_cnt   = '0;
          w_idx   = '0;
        end else begin
          w_rst[r_idx] = OUTPUT_POLARITY;
          if (r_idx != '0) w_idx = r_idx - IDX_W'(1);
        end
      end
`endif
      default: begin
        w_state = ST_HOLD;
      end
    endcase

`ifdef RESET_STAGGER_ASSERT_EN
    if (bus.soft_reset_req_i && (r_state != ST_SHUTDOWN)) begin
      w_state                  = ST_SHUTDOWN;
      w_rst                    = r_rst;
      w_rst[NUM_DOMAINS-1]     = OUTPUT_POLARITY;
      w_idx                    = (NUM_DOMAINS > 1) ? (LAST_IDX - IDX_W'(1)) : '0;
      w_cnt                    = '0;
      w_tmr                    = '0;
      w_all_ready              = 1'b0;
      w_busy                   = 1'b1;
      w_timeout_err            = r_timeout_err;
    end
`else
    if (bus.soft_reset_req_i) begin
      w_state       = ST_HOLD;
      w_rst         = ALL_ASSERTED;
      w_idx         = '0;
      w_cnt         = '0;
      w_tmr         = '0;
      w_all_ready   = 1'b0;
      w_busy        = 1'b1;
      w_timeout_err = r_timeout_err;
    end
`endif
  end

  assign bus.domain_reset_o = r_rst;
  assign bus.all_ready_o    = r_all_ready;
  assign bus.busy_o         = r_busy;
  assign bus.timeout_err_o  = r_timeout_err;
  assign bus.cur_domain_o   = r_idx;
endmodule
